// File: rtl/bsg_axil_mux_pkg.sv
// Shared types for the AXI-Lite multi-master mux.
// Bus structs, FSM state enums, response codes.
package bsg_axil_mux_pkg;

   localparam int axil_addr_width_lp = 32;
   localparam int axil_data_width_lp = 32;
   localparam int axil_strb_width_lp = axil_data_width_lp / 8;

   localparam logic [1:0] axil_resp_okay_lp = 2'b00;

   typedef enum logic [1:0] {
      E_WR_IDLE,
      E_WR_XFER,
      E_WR_RESP
   } wr_state_e;

   typedef enum logic [1:0] {
      E_RD_IDLE,
      E_RD_ADDR,
      E_RD_DATA
   } rd_state_e;

   typedef struct packed {
      logic [axil_addr_width_lp-1:0] awaddr;
      logic [2:0]                    awprot;
      logic                          awvalid;
      logic [axil_data_width_lp-1:0] wdata;
      logic [axil_strb_width_lp-1:0] wstrb;
      logic                          wvalid;
      logic                          bready;
      logic [axil_addr_width_lp-1:0] araddr;
      logic [2:0]                    arprot;
      logic                          arvalid;
      logic                          rready;
   } bsg_axil_mosi_s;

   typedef struct packed {
      logic                          awready;
      logic                          wready;
      logic [1:0]                    bresp;
      logic                          bvalid;
      logic                          arready;
      logic [axil_data_width_lp-1:0] rdata;
      logic [1:0]                    rresp;
      logic                          rvalid;
   } bsg_axil_miso_s;

   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bsg_axil_mux_rr_arb.sv
// Round-robin requester select with completion-advanced pointer.
// Define BSG_AXIL_MUX_FIXED_PRIO_EN for fixed lowest-index priority.
module bsg_axil_mux_rr_arb
   import bsg_axil_mux_pkg::*;
 #(parameter int num_masters_p = 2
  ,localparam int lg_lp = safe_clog2(num_masters_p)
  )
  (input  logic                     clk_i
  ,input  logic                     reset_i
  ,input  logic [num_masters_p-1:0] req_i
  ,input  logic                     advance_i
  ,input  logic [lg_lp-1:0]         adv_id_i
  ,output logic [lg_lp-1:0]         grant_o
  ,output logic                     grant_v_o
  );

   logic [lg_lp-1:0]         ptr_r;
   logic [num_masters_p-1:0] rot;
   logic [lg_lp:0]           sum;

`ifdef BSG_AXIL_MUX_FIXED_PRIO_EN
   assign ptr_r = '0;
   wire unused_arb = ^{clk_i, reset_i, advance_i, adv_id_i};
`else
   // Pointer moves past the master whose transaction just completed.
   always_ff @(posedge clk_i) begin
      if (reset_i)
         ptr_r <= '0;
      else if (advance_i)
         ptr_r <= (adv_id_i == lg_lp'(num_masters_p-1))
                  ? '0 : adv_id_i + 1'b1;
   end
`endif

   // Rotate so ptr sits at bit 0, then take the first request.
   assign rot = num_masters_p'({req_i, req_i} >> ptr_r);

   // First set bit of the rotated vector, mapped back to an index.
   always_comb begin
      grant_o   = '0;
      grant_v_o = 1'b0;
      sum       = '0;
      for (int i = 0; i < num_masters_p; i++) begin
         if (!grant_v_o && rot[i]) begin
            grant_v_o = 1'b1;
            sum = {1'b0, ptr_r} + (lg_lp+1)'(i);
            if (sum > (lg_lp+1)'(num_masters_p-1))
               sum = sum - (lg_lp+1)'(num_masters_p);
            grant_o = sum[lg_lp-1:0];
         end
      end
   end

endmodule

// File: rtl/bsg_axil_mux.sv
// N-to-1 AXI-Lite mux, independent read/write arbiters.
// Define BSG_AXIL_MUX_FIXED_PRIO_EN for fixed priority.
module bsg_axil_mux
   import bsg_axil_mux_pkg::*;
 #(parameter int num_masters_p = 2
  ,localparam int lg_lp = safe_clog2(num_masters_p)
  )
  (input  logic                                 clk_i
  ,input  logic                                 reset_i
  ,input  bsg_axil_mosi_s [num_masters_p-1:0] s_axil_bus_i
  ,output bsg_axil_miso_s [num_masters_p-1:0] s_axil_bus_o
  ,output bsg_axil_mosi_s                     m_axil_bus_o
  ,input  bsg_axil_miso_s                     m_axil_bus_i
  );

   wr_state_e        wr_state_r, wr_state_n;
   rd_state_e        rd_state_r, rd_state_n;
   logic [lg_lp-1:0] wr_grant_r, wr_grant_n;
   logic [lg_lp-1:0] rd_grant_r, rd_grant_n;
   logic             aw_done_r, aw_done_n;
   logic             w_done_r, w_done_n;
   logic             aw_hs, w_hs;
   logic             wr_adv, rd_adv;

   logic [num_masters_p-1:0] aw_req, ar_req;
   logic [lg_lp-1:0]         wr_arb_grant, rd_arb_grant;
   logic                     wr_arb_v, rd_arb_v;

   bsg_axil_mosi_s wr_mosi, rd_mosi;

   assign wr_mosi = s_axil_bus_i[wr_grant_r];
   assign rd_mosi = s_axil_bus_i[rd_grant_r];

   // Collect per-master address requests for the two arbiters.
   always_comb begin
      aw_req = '0;
      ar_req = '0;
      for (int i = 0; i < num_masters_p; i++) begin
         aw_req[i] = s_axil_bus_i[i].awvalid;
         ar_req[i] = s_axil_bus_i[i].arvalid;
      end
   end

   bsg_axil_mux_rr_arb #(.num_masters_p(num_masters_p)) wr_arb
     (.clk_i     (clk_i)
     ,.reset_i   (reset_i)
     ,.req_i     (aw_req)
     ,.advance_i (wr_adv)
     ,.adv_id_i  (wr_grant_r)
     ,.grant_o   (wr_arb_grant)
     ,.grant_v_o (wr_arb_v)
     );

   bsg_axil_mux_rr_arb #(.num_masters_p(num_masters_p)) rd_arb
     (.clk_i     (clk_i)
     ,.reset_i   (reset_i)
     ,.req_i     (ar_req)
     ,.advance_i (rd_adv)
     ,.adv_id_i  (rd_grant_r)
     ,.grant_o   (rd_arb_grant)
     ,.grant_v_o (rd_arb_v)
     );

   // FSM state, grants and aw/w completion flags.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_state_r <= E_WR_IDLE;
         rd_state_r <= E_RD_IDLE;
         wr_grant_r <= '0;
         rd_grant_r <= '0;
         aw_done_r  <= 1'b0;
         w_done_r   <= 1'b0;
      end else begin
         wr_state_r <= wr_state_n;
         rd_state_r <= rd_state_n;
         wr_grant_r <= wr_grant_n;
         rd_grant_r <= rd_grant_n;
         aw_done_r  <= aw_done_n;
         w_done_r   <= w_done_n;
      end
   end

   // Write path: grant, aw/w handshakes in any order, then b.
   always_comb begin
      wr_state_n = wr_state_r;
      wr_grant_n = wr_grant_r;
      aw_done_n  = aw_done_r;
      w_done_n   = w_done_r;
      wr_adv     = 1'b0;
      aw_hs      = 1'b0;
      w_hs       = 1'b0;
      unique case (wr_state_r)
         E_WR_IDLE: begin
            if (wr_arb_v) begin
               wr_grant_n = wr_arb_grant;
               wr_state_n = E_WR_XFER;
            end
         end
         E_WR_XFER: begin
            aw_hs = wr_mosi.awvalid & ~aw_done_r
                  & m_axil_bus_i.awready;
            w_hs  = wr_mosi.wvalid & ~w_done_r
                  & m_axil_bus_i.wready;
            if (aw_hs) aw_done_n = 1'b1;
            if (w_hs)  w_done_n  = 1'b1;
            if ((aw_done_r | aw_hs) & (w_done_r | w_hs))
               wr_state_n = E_WR_RESP;
         end
         E_WR_RESP: begin
            if (m_axil_bus_i.bvalid & wr_mosi.bready) begin
               wr_state_n = E_WR_IDLE;
               wr_adv     = 1'b1;
               aw_done_n  = 1'b0;
               w_done_n   = 1'b0;
            end
         end
         default: wr_state_n = E_WR_IDLE;
      endcase
   end

   // Read path: grant, ar handshake, then r.
   always_comb begin
      rd_state_n = rd_state_r;
      rd_grant_n = rd_grant_r;
      rd_adv     = 1'b0;
      unique case (rd_state_r)
         E_RD_IDLE: begin
            if (rd_arb_v) begin
               rd_grant_n = rd_arb_grant;
               rd_state_n = E_RD_ADDR;
            end
         end
         E_RD_ADDR: begin
            if (rd_mosi.arvalid & m_axil_bus_i.arready)
               rd_state_n = E_RD_DATA;
         end
         E_RD_DATA: begin
            if (m_axil_bus_i.rvalid & rd_mosi.rready) begin
               rd_state_n = E_RD_IDLE;
               rd_adv     = 1'b1;
            end
         end
         default: rd_state_n = E_RD_IDLE;
      endcase
   end

   // Pass-through to/from the granted master; reset blanks all.
   always_comb begin
      m_axil_bus_o = '0;
      s_axil_bus_o = '0;
      for (int i = 0; i < num_masters_p; i++) begin
         s_axil_bus_o[i].bresp = axil_resp_okay_lp;
         s_axil_bus_o[i].rresp = axil_resp_okay_lp;
      end
      if (!reset_i) begin
         if (wr_state_r == E_WR_XFER) begin
            m_axil_bus_o.awaddr  = wr_mosi.awaddr;
            m_axil_bus_o.awprot  = wr_mosi.awprot;
            m_axil_bus_o.awvalid = wr_mosi.awvalid & ~aw_done_r;
            m_axil_bus_o.wdata   = wr_mosi.wdata;
            m_axil_bus_o.wstrb   = wr_mosi.wstrb;
            m_axil_bus_o.wvalid  = wr_mosi.wvalid & ~w_done_r;
            s_axil_bus_o[wr_grant_r].awready =
               m_axil_bus_i.awready & ~aw_done_r;
            s_axil_bus_o[wr_grant_r].wready =
               m_axil_bus_i.wready & ~w_done_r;
         end
         if (wr_state_r == E_WR_RESP) begin
            m_axil_bus_o.bready = wr_mosi.bready;
            s_axil_bus_o[wr_grant_r].bvalid = m_axil_bus_i.bvalid;
            s_axil_bus_o[wr_grant_r].bresp  = m_axil_bus_i.bresp;
         end
         if (rd_state_r == E_RD_ADDR) begin
            m_axil_bus_o.araddr  = rd_mosi.araddr;
            m_axil_bus_o.arprot  = rd_mosi.arprot;
            m_axil_bus_o.arvalid = rd_mosi.arvalid;
            s_axil_bus_o[rd_grant_r].arready = m_axil_bus_i.arready;
         end
         if (rd_state_r == E_RD_DATA) begin
            m_axil_bus_o.rready = rd_mosi.rready;
            s_axil_bus_o[rd_grant_r].rvalid = m_axil_bus_i.rvalid;
            s_axil_bus_o[rd_grant_r].rdata  = m_axil_bus_i.rdata;
            s_axil_bus_o[rd_grant_r].rresp  = m_axil_bus_i.rresp;
         end
      end
   end

endmodule

// File: tb/tb_bsg_axil_mux.sv
// Directed bench for bsg_axil_mux with two masters.
// Honours BSG_AXIL_MUX_FIXED_PRIO_EN for expected grant order.
module tb_bsg_axil_mux;
   import bsg_axil_mux_pkg::*;

   logic clk = 1'b0;
   logic reset_i;
   bsg_axil_mosi_s [1:0] s_in;
   bsg_axil_miso_s [1:0] s_out;
   bsg_axil_mosi_s       m_out;
   bsg_axil_miso_s       m_in;

   int checks = 0;
   int errors = 0;
   int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
   int exp_g [3];

   always #5 clk = ~clk;

   bsg_axil_mux #(.num_masters_p(2)) dut
     (.clk_i        (clk)
     ,.reset_i      (reset_i)
     ,.s_axil_bus_i (s_in)
     ,.s_axil_bus_o (s_out)
     ,.m_axil_bus_o (m_out)
     ,.m_axil_bus_i (m_in)
     );

   // Slave-side handshake counters, sampled late in the cycle.
   always begin
      @(negedge clk);
      #3;
      if (m_out.awvalid && m_in.awready) aw_cnt++;
      if (m_out.wvalid  && m_in.wready)  w_cnt++;
      if (m_out.arvalid && m_in.arready) ar_cnt++;
      if (m_out.rready  && m_in.rvalid)  r_cnt++;
   end

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
`ifdef BSG_AXIL_MUX_FIXED_PRIO_EN
      exp_g = '{0, 0, 0};
`else
      exp_g = '{0, 1, 0};
`endif
      // Reset with every master requesting: all outputs quiet.
      reset_i = 1'b1;
      m_in = '0;
      for (int i = 0; i < 2; i++) begin
         s_in[i] = '0;
         s_in[i].awvalid = 1'b1;
         s_in[i].wvalid  = 1'b1;
         s_in[i].bready  = 1'b1;
         s_in[i].arvalid = 1'b1;
         s_in[i].rready  = 1'b1;
      end
      m_in.awready = 1'b1;
      m_in.bvalid  = 1'b1;
      m_in.rvalid  = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_m_out", m_out, '0);
      chk("rst_s_out", s_out, '0);
      @(negedge clk);
      reset_i = 1'b0;
      s_in = '0;
      m_in = '0;
      #1;
      chk("post_rst_s_out", s_out, '0);

      // Single write from master 1.
      @(negedge clk);
      m_in.awready = 1'b1;
      m_in.wready  = 1'b1;
      m_in.arready = 1'b1;
      s_in[1].awaddr  = 32'h110;
      s_in[1].awvalid = 1'b1;
      s_in[1].wdata   = 32'hA5A5_0001;
      s_in[1].wstrb   = 4'hF;
      s_in[1].wvalid  = 1'b1;
      s_in[1].bready  = 1'b1;
      #1;
      chk("t1_idle_awvalid", m_out.awvalid, 1'b0);
      @(negedge clk);
      #1;
      chk("t1_awaddr", m_out.awaddr, 32'h110);
      chk("t1_awvalid", m_out.awvalid, 1'b1);
      chk("t1_wdata", m_out.wdata, 32'hA5A5_0001);
      chk("t1_wstrb", m_out.wstrb, 4'hF);
      chk("t1_m1_awready", s_out[1].awready, 1'b1);
      chk("t1_m1_wready", s_out[1].wready, 1'b1);
      chk("t1_m0_awready", s_out[0].awready, 1'b0);
      chk("t1_m0_wready", s_out[0].wready, 1'b0);
      @(negedge clk);
      s_in[1].awvalid = 1'b0;
      s_in[1].wvalid  = 1'b0;
      m_in.bvalid = 1'b1;
      m_in.bresp  = 2'b10;
      #1;
      chk("t1_bready", m_out.bready, 1'b1);
      chk("t1_m1_bvalid", s_out[1].bvalid, 1'b1);
      chk("t1_m1_bresp", s_out[1].bresp, 2'b10);
      chk("t1_m0_bvalid", s_out[0].bvalid, 1'b0);
      chk("t1_resp_awvalid", m_out.awvalid, 1'b0);
      @(negedge clk);
      m_in.bvalid = 1'b0;
      m_in.bresp  = 2'b00;
      s_in[1] = '0;
      #1;
      chk("t1_done_bvalid", s_out[1].bvalid, 1'b0);

      // Both masters write continuously; grant order checked.
      @(negedge clk);
      s_in[0].awaddr = 32'h200;
      s_in[0].wdata  = 32'h0000_0200;
      s_in[1].awaddr = 32'h204;
      s_in[1].wdata  = 32'h0000_0204;
      for (int i = 0; i < 2; i++) begin
         s_in[i].awvalid = 1'b1;
         s_in[i].wvalid  = 1'b1;
         s_in[i].wstrb   = 4'hF;
         s_in[i].bready  = 1'b1;
      end
      m_in.bvalid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t2_idle_awvalid", m_out.awvalid, 1'b0);
         @(negedge clk);
         #1;
         chk("t2_grant_awready", s_out[exp_g[k]].awready, 1'b1);
         chk("t2_other_awready", s_out[1-exp_g[k]].awready, 1'b0);
         chk("t2_awaddr", m_out.awaddr,
             (exp_g[k] == 1) ? 32'h204 : 32'h200);
         @(negedge clk);
         #1;
         chk("t2_grant_bvalid", s_out[exp_g[k]].bvalid, 1'b1);
         chk("t2_other_bvalid", s_out[1-exp_g[k]].bvalid, 1'b0);
         @(negedge clk);
      end
      s_in = '0;
      m_in.bvalid = 1'b0;

      // Slave takes w two cycles before aw.
      @(negedge clk);
      s_in[0].awaddr  = 32'h300;
      s_in[0].awvalid = 1'b1;
      s_in[0].wdata   = 32'h3333_0003;
      s_in[0].wstrb   = 4'hF;
      s_in[0].wvalid  = 1'b1;
      s_in[0].bready  = 1'b1;
      m_in.awready = 1'b0;
      m_in.wready  = 1'b1;
      @(negedge clk);
      #1;
      chk("t3_wvalid", m_out.wvalid, 1'b1);
      chk("t3_m0_wready", s_out[0].wready, 1'b1);
      chk("t3_m0_awready_lo", s_out[0].awready, 1'b0);
      @(negedge clk);
      #1;
      chk("t3_wvalid_forced", m_out.wvalid, 1'b0);
      chk("t3_m0_wready_done", s_out[0].wready, 1'b0);
      chk("t3_awvalid_held", m_out.awvalid, 1'b1);
      chk("t3_no_resp_yet", m_out.bready, 1'b0);
      @(negedge clk);
      m_in.awready = 1'b1;
      #1;
      chk("t3_m0_awready", s_out[0].awready, 1'b1);
      chk("t3_still_xfer", m_out.bready, 1'b0);
      @(negedge clk);
      s_in[0].awvalid = 1'b0;
      s_in[0].wvalid  = 1'b0;
      m_in.bvalid = 1'b1;
      #1;
      chk("t3_resp_bready", m_out.bready, 1'b1);
      chk("t3_m0_bvalid", s_out[0].bvalid, 1'b1);
      @(negedge clk);
      s_in[0] = '0;
      m_in.bvalid = 1'b0;
      #1;
      chk("t3_idle_bready", m_out.bready, 1'b0);

      // Concurrent read by master 0 and write by master 1.
      @(negedge clk);
      s_in[0].araddr  = 32'h01C;
      s_in[0].arvalid = 1'b1;
      s_in[0].rready  = 1'b1;
      s_in[1].awaddr  = 32'h010;
      s_in[1].awvalid = 1'b1;
      s_in[1].wdata   = 32'h1010_1010;
      s_in[1].wstrb   = 4'hF;
      s_in[1].wvalid  = 1'b1;
      s_in[1].bready  = 1'b1;
      m_in.arready = 1'b1;
      m_in.rvalid  = 1'b1;
      m_in.rdata   = 32'hDEAD_BEEF;
      m_in.bvalid  = 1'b1;
      #1;
      chk("t4_idle_arvalid", m_out.arvalid, 1'b0);
      @(negedge clk);
      #1;
      chk("t4_arvalid", m_out.arvalid, 1'b1);
      chk("t4_araddr", m_out.araddr, 32'h01C);
      chk("t4_awaddr", m_out.awaddr, 32'h010);
      chk("t4_m0_arready", s_out[0].arready, 1'b1);
      chk("t4_m1_arready", s_out[1].arready, 1'b0);
      chk("t4_m1_awready", s_out[1].awready, 1'b1);
      chk("t4_m0_awready", s_out[0].awready, 1'b0);
      @(negedge clk);
      s_in[0].arvalid = 1'b0;
      s_in[1].awvalid = 1'b0;
      s_in[1].wvalid  = 1'b0;
      #1;
      chk("t4_m0_rvalid", s_out[0].rvalid, 1'b1);
      chk("t4_m0_rdata", s_out[0].rdata, 32'hDEAD_BEEF);
      chk("t4_m1_rvalid", s_out[1].rvalid, 1'b0);
      chk("t4_m1_rdata", s_out[1].rdata, 32'h0);
      chk("t4_m1_bvalid", s_out[1].bvalid, 1'b1);
      chk("t4_m0_bvalid", s_out[0].bvalid, 1'b0);
      chk("t4_rready", m_out.rready, 1'b1);
      @(negedge clk);
      s_in = '0;
      m_in.rvalid = 1'b0;
      m_in.rdata  = '0;
      m_in.bvalid = 1'b0;
      #1;
      chk("t4_idle_rready", m_out.rready, 1'b0);

      // Slave withholds bvalid for 20 cycles; master 1 waits.
      @(negedge clk);
      s_in[0].awaddr = 32'h500;
      s_in[0].wdata  = 32'h0000_0500;
      s_in[1].awaddr = 32'h504;
      s_in[1].wdata  = 32'h0000_0504;
      for (int i = 0; i < 2; i++) begin
         s_in[i].awvalid = 1'b1;
         s_in[i].wvalid  = 1'b1;
         s_in[i].wstrb   = 4'hF;
         s_in[i].bready  = 1'b1;
      end
      @(negedge clk);
      #1;
      chk("t5_m0_awready", s_out[0].awready, 1'b1);
      chk("t5_m1_awready", s_out[1].awready, 1'b0);
      @(negedge clk);
      s_in[0].awvalid = 1'b0;
      s_in[0].wvalid  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("t5_stall_bvalid", s_out[0].bvalid, 1'b0);
         chk("t5_stall_m1_awready", s_out[1].awready, 1'b0);
         chk("t5_stall_bready", m_out.bready, 1'b1);
         @(negedge clk);
      end
      m_in.bvalid = 1'b1;
      #1;
      chk("t5_m0_bvalid", s_out[0].bvalid, 1'b1);
      @(negedge clk);
      s_in[0] = '0;
      #1;
      chk("t5_idle_awvalid", m_out.awvalid, 1'b0);
      @(negedge clk);
      #1;
      chk("t5_m1_awready_go", s_out[1].awready, 1'b1);
      chk("t5_m1_awaddr", m_out.awaddr, 32'h504);
      @(negedge clk);
      s_in[1].awvalid = 1'b0;
      s_in[1].wvalid  = 1'b0;
      #1;
      chk("t5_m1_bvalid", s_out[1].bvalid, 1'b1);
      @(negedge clk);
      s_in = '0;
      m_in.bvalid = 1'b0;

      // Reset while waiting for b, then a fresh write.
      @(negedge clk);
      s_in[0].awaddr  = 32'h130;
      s_in[0].awvalid = 1'b1;
      s_in[0].wdata   = 32'h0000_0130;
      s_in[0].wstrb   = 4'hF;
      s_in[0].wvalid  = 1'b1;
      s_in[0].bready  = 1'b1;
      @(negedge clk);
      #1;
      chk("t6_m0_awready", s_out[0].awready, 1'b1);
      @(negedge clk);
      s_in[0].awvalid = 1'b0;
      s_in[0].wvalid  = 1'b0;
      reset_i = 1'b1;
      #1;
      chk("t6_rst_m_out", m_out, '0);
      chk("t6_rst_s_out", s_out, '0);
      @(negedge clk);
      #1;
      chk("t6_rst2_m_out", m_out, '0);
      chk("t6_rst2_s_out", s_out, '0);
      reset_i = 1'b0;
      s_in = '0;
      m_in.bvalid = 1'b1;
      @(negedge clk);
      s_in[1].awaddr  = 32'h120;
      s_in[1].awvalid = 1'b1;
      s_in[1].wdata   = 32'h1200_0120;
      s_in[1].wstrb   = 4'hF;
      s_in[1].wvalid  = 1'b1;
      s_in[1].bready  = 1'b1;
      #1;
      chk("t6_idle_bready", m_out.bready, 1'b0);
      @(negedge clk);
      #1;
      chk("t6_m1_awready", s_out[1].awready, 1'b1);
      chk("t6_awaddr", m_out.awaddr, 32'h120);
      chk("t6_wdata", m_out.wdata, 32'h1200_0120);
      @(negedge clk);
      s_in[1].awvalid = 1'b0;
      s_in[1].wvalid  = 1'b0;
      #1;
      chk("t6_m1_bvalid", s_out[1].bvalid, 1'b1);
      @(negedge clk);
      s_in = '0;
      m_in = '0;
      repeat (2) @(negedge clk);

      chk("aw_handshakes", aw_cnt, 10);
      chk("w_handshakes", w_cnt, 10);
      chk("ar_handshakes", ar_cnt, 1);
      chk("r_handshakes", r_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
